// File: rtl/bsg_chip_period_meter.sv
// Measures the period of a synchronized monitor signal in clk_i cycles,
// averaging 2^samples_lg_p periods per result, with saturation reporting.
module bsg_chip_period_meter #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned samples_lg_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               sig_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] period_o,
  output logic               ovf_o
);

  localparam int unsigned acc_width_lp = width_p + samples_lg_p;
  localparam int unsigned n_width_lp   = (samples_lg_p > 0) ? samples_lg_p : 1;
  localparam logic [n_width_lp-1:0] n_max_lp =
    n_width_lp'((64'(1) << samples_lg_p) - 64'(1));
  localparam logic [width_p-1:0] cnt_max_lp = {width_p{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                  state_r, state_n;
  logic                    sig_r;
  logic [width_p-1:0]      cnt_r, cnt_n;
  logic [acc_width_lp-1:0] acc_r, acc_n, acc_sum;
  logic [n_width_lp-1:0]   n_r, n_n;
  logic [width_p-1:0]      period_r, period_n;
  logic                    ovf_r, ovf_n;
  logic                    v_r;
  logic                    rise;

  // sig_r resets high so a level held through reset is not seen as an edge
  assign rise    = sig_i & ~sig_r;
  assign acc_sum = acc_r + acc_width_lp'(cnt_r);

  // State, counters and result registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= IDLE;
      sig_r    <= 1'b1;
      cnt_r    <= '0;
      acc_r    <= '0;
      n_r      <= '0;
      period_r <= '0;
      ovf_r    <= 1'b0;
      v_r      <= 1'b0;
    end else begin
      state_r  <= state_n;
      sig_r    <= sig_i;
      cnt_r    <= cnt_n;
      acc_r    <= acc_n;
      n_r      <= n_n;
      period_r <= period_n;
      ovf_r    <= ovf_n;
      v_r      <= (state_n == DONE);
    end
  end

  // Next-state and datapath updates; en_i dominates rise and saturation
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    acc_n    = acc_r;
    n_n      = n_r;
    period_n = period_r;
    ovf_n    = ovf_r;

    unique case (state_r)
      IDLE: begin
        if (en_i) state_n = ARM;
      end

      ARM: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (rise) begin
          state_n = MEASURE;
          cnt_n   = width_p'(1);
          acc_n   = '0;
          n_n     = '0;
        end
      end

      MEASURE: begin
        if (!en_i) begin
          state_n = IDLE;
        end else if (rise) begin
          if (n_r == n_max_lp) begin
            state_n  = DONE;
            period_n = width_p'(acc_sum >> samples_lg_p);
            ovf_n    = 1'b0;
          end else begin
            acc_n = acc_sum;
            cnt_n = width_p'(1);
            n_n   = n_r + n_width_lp'(1);
          end
        end else if (cnt_r == cnt_max_lp) begin
          state_n  = DONE;
          period_n = cnt_max_lp;
          ovf_n    = 1'b1;
        end else begin
          cnt_n = cnt_r + width_p'(1);
        end
      end

      DONE: begin
        // Result is held until consumed regardless of en_i
        if (yumi_i) state_n = en_i ? ARM : IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign v_o      = v_r;
  assign period_o = period_r;
  assign ovf_o    = ovf_r;

endmodule

// File: tb/tb_bsg_chip_period_meter.sv
// Directed self-checking bench for bsg_chip_period_meter (width_p=8, samples_lg_p=2).
module tb_bsg_chip_period_meter;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       sig = 1'b0;
  logic       yumi = 1'b0;
  logic       v;
  logic [7:0] period;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  bsg_chip_period_meter #(.width_p(8), .samples_lg_p(2)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (en),
    .sig_i   (sig),
    .v_o     (v),
    .yumi_i  (yumi),
    .period_o(period),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full period of p cycles starting with a rise; sig ends low
  task automatic drive_period(input int p);
    sig = 1'b1;
    repeat ((p + 1) / 2) step();
    sig = 1'b0;
    repeat (p - (p + 1) / 2) step();
  endtask

  // Four periods followed by the closing rise; result is visible afterwards
  task automatic drive_four(input int p0, input int p1, input int p2, input int p3);
    drive_period(p0);
    drive_period(p1);
    drive_period(p2);
    drive_period(p3);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: v_o=%0b required 0", v);
    end
    sig = 1'b1;
    step();
  endtask

  task automatic check_result(input string name, input logic [7:0] exp_p, input logic exp_o);
    checks++;
    if (v !== 1'b1 || period !== exp_p || ovf !== exp_o) begin
      errors++;
      $display("FAIL %s: v_o=%0b period_o=%0d ovf_o=%0b required v_o=1 period_o=%0d ovf_o=%0b",
               name, v, period, ovf, exp_p, exp_o);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp_s);
    checks++;
    if (dut.state_r !== exp_s) begin
      errors++;
      $display("FAIL %s: state=%0d required %0d", name, dut.state_r, exp_s);
    end
  endtask

  task automatic handshake(input string name, input logic en_after);
    en   = en_after;
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL %s_v: v_o=%0b required 0", name, v);
    end
    check_state(name, en_after ? S_ARM : S_IDLE);
  endtask

  task automatic test_reset();
    reset = 1'b1; sig = 1'b1; en = 1'b0; yumi = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (v !== 1'b0 || period !== 8'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: v_o=%0b period_o=%0d ovf_o=%0b required 0 0 0", v, period, ovf);
    end
    check_state("reset_idle", S_IDLE);
    // sig held high: no rise, and a stray yumi is ignored
    en = 1'b1; yumi = 1'b1;
    step(); step(); step();
    yumi = 1'b0;
    check_state("reset_no_rise", S_ARM);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL stray_yumi: v_o=%0b required 0", v);
    end
  endtask

  task automatic test_basic();
    sig = 1'b0;
    step();
    drive_four(10, 10, 10, 10);
    check_result("basic_10", 8'd10, 1'b0);
    handshake("basic_hs", 1'b1);
  endtask

  task automatic test_average();
    sig = 1'b0;
    step(); step();
    drive_four(9, 10, 11, 12);
    check_result("avg_42", 8'd10, 1'b0);
    handshake("avg_hs", 1'b1);
    sig = 1'b0; step();
    drive_four(3, 3, 3, 4);
    check_result("avg_trunc_13", 8'd3, 1'b0);
    handshake("trunc_hs", 1'b1);
    sig = 1'b0; step();
    drive_four(2, 2, 2, 2);
    check_result("avg_min_2", 8'd2, 1'b0);
  endtask

  task automatic test_hold();
    logic [7:0] p0;
    logic       ok;
    p0 = period;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      en  = i[0];
      sig = i[1];
      step();
      if (v !== 1'b1 || period !== 8'd2 || ovf !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || p0 !== 8'd2) begin
      errors++;
      $display("FAIL hold: v_o=%0b period_o=%0d ovf_o=%0b required 1 2 0", v, period, ovf);
    end
    // rise coincident with yumi must not start a measurement
    sig = 1'b0; step();
    sig = 1'b1;
    handshake("hold_hs", 1'b1);
    step(); step();
    check_state("hold_rise_ignored", S_ARM);
  endtask

  task automatic test_saturation();
    sig = 1'b0; step();
    sig = 1'b1; step();
    sig = 1'b0;
    repeat (254) step();
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL sat_early: v_o=%0b required 0", v);
    end
    step();
    check_result("saturate", 8'd255, 1'b1);
    handshake("sat_hs", 1'b0);
  endtask

  task automatic test_abort();
    logic rose;
    rose = 1'b0;
    en = 1'b1; sig = 1'b0;
    step(); step();
    drive_period(10);
    drive_period(10);
    sig = 1'b1; step(); step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (v !== 1'b0) rose = 1'b1;
    end
    check_state("abort_idle", S_IDLE);
    checks++;
    if (rose || period !== 8'd255 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet: rose=%0b period_o=%0d ovf_o=%0b required 0 255 1", rose, period, ovf);
    end
    sig = 1'b0; en = 1'b1;
    step();
    drive_four(8, 8, 8, 8);
    check_result("abort_fresh", 8'd8, 1'b0);
  endtask

  task automatic test_reset_in_done();
    sig = 1'b1; yumi = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; yumi = 1'b0; en = 1'b1;
    checks++;
    if (v !== 1'b0 || period !== 8'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: v_o=%0b period_o=%0d ovf_o=%0b required 0 0 0", v, period, ovf);
    end
    repeat (4) step();
    check_state("post_reset_no_rise", S_ARM);
    sig = 1'b0; step();
    sig = 1'b1; step();
    check_state("post_reset_rise", S_MEASURE);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_hold();
    test_saturation();
    test_abort();
    test_reset_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_chip_period_meter.md
BSG_CHIP_PERIOD_METER -- requirements
Module: bsg_chip_period_meter

Interface
REQ-001 The block SHALL take parameter width_p, default 8: period counter width in bits, matching the delay-line period approximator width.
REQ-002 The block SHALL take parameter samples_lg_p, default 2: log2 of the number of periods averaged per result.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port en_i, input, 1 bit: measurement enable, from the monitor tag client.
REQ-006 The block SHALL have port sig_i, input, 1 bit: the monitored signal (osc or dly), already synchronized to clk_i.
REQ-007 The block SHALL have port v_o, output, 1 bit: result valid.
REQ-008 The block SHALL have port yumi_i, input, 1 bit: consumer accepts the result; it is legal only while v_o=1.
REQ-009 The block SHALL have port period_o, output, width_p bits: the averaged period in clk_i cycles.
REQ-010 The block SHALL have port ovf_o, output, 1 bit: the current result was aborted by counter saturation.

Function
REQ-011 The block SHALL register sig_r <= sig_i every cycle; rise = sig_i & ~sig_r.
REQ-012 The block SHALL implement FSM states IDLE, ARM, MEASURE, DONE.
REQ-013 IDLE: if en_i=1, the FSM SHALL go to ARM on the next cycle; otherwise it SHALL stay in IDLE.
REQ-014 ARM: on rise, the FSM SHALL go to MEASURE with cnt<=1, acc<=0, n<=0; on en_i=0 it SHALL go to IDLE.
REQ-015 MEASURE, no rise, cnt<2^width_p-1: the block SHALL set cnt<=cnt+1.
REQ-016 MEASURE, rise: the block SHALL set acc<=acc+cnt, cnt<=1, n<=n+1; the measured period equals the cycle distance between successive rise cycles (rises at t and t+P capture cnt=P).
REQ-017 MEASURE, rise with n=2^samples_lg_p-1: the FSM SHALL go to DONE with period_o<=(acc+cnt)>>samples_lg_p (truncating) and ovf_o<=0.
REQ-018 MEASURE, no rise with cnt=2^width_p-1: the FSM SHALL go to DONE with period_o<=2^width_p-1 and ovf_o<=1; the partial acc SHALL be discarded.
REQ-019 MEASURE, en_i=0: the FSM SHALL go to IDLE with no result, and the en_i check SHALL take priority over rise and saturation.
REQ-020 acc SHALL be width_p+samples_lg_p bits wide and SHALL never overflow.
REQ-021 DONE: v_o SHALL be 1, and period_o and ovf_o SHALL be held stable until yumi_i.
REQ-022 DONE with yumi_i=1: v_o SHALL be 0 on the next cycle; the FSM SHALL go to ARM if en_i=1, else to IDLE.
REQ-023 DONE SHALL ignore en_i until yumi_i; the result SHALL never be dropped.
REQ-024 yumi_i while v_o=0 SHALL be ignored.
REQ-025 v_o SHALL be 1 exactly when the state is DONE; period_o and ovf_o SHALL keep their last values outside DONE.
REQ-026 After a handshake, the next measurement SHALL wait for a fresh rise in ARM; a rise coincident with yumi_i SHALL NOT be counted.

Reset
REQ-027 While reset_i=1 at a clock edge, the block SHALL set state=IDLE, v_o=0, period_o=0, ovf_o=0, cnt=0, acc=0, n=0, sig_r=1.
REQ-028 Because sig_r resets to 1, a sig_i held high through reset SHALL produce no spurious rise.
REQ-029 reset_i SHALL override every state, including DONE with v_o=1 and a yumi_i in the same cycle; v_o SHALL be 0 on the cycle after the reset edge.

Verification (width_p=8, samples_lg_p=2)
REQ-030 The bench SHALL drive en_i=1 with sig_i at a 10-cycle period (5 high, 5 low), and SHALL check v_o=1 one cycle after the 5th rise with period_o=10 and ovf_o=0.
REQ-031 The bench SHALL drive successive periods of 9, 10, 11, 12 (sum 42), and SHALL check period_o=10 and ovf_o=0.
REQ-032 The bench SHALL arm the block with one rise at cycle t and then hold sig_i low, and SHALL check v_o=1 at cycle t+256 with period_o=255 and ovf_o=1.
REQ-033 The bench SHALL hold yumi_i=0 for 20 cycles in DONE and check that v_o, period_o and ovf_o stay constant; it SHALL then pulse yumi_i and check v_o=0 on the next cycle and the FSM in ARM.
REQ-034 The bench SHALL drop en_i during MEASURE after 2 periods, and SHALL check the FSM reaches IDLE and v_o never rises; it SHALL then re-enable en_i and check that a full fresh 4-period result follows.
REQ-035 The bench SHALL assert reset_i with sig_i=1 while in DONE with yumi_i=1, and SHALL check that on the next cycle v_o=0 and period_o=0, and that no rise is detected after release until sig_i goes low then high.
